// File: rtl/ahb_sram_subordinate.sv
// AHB-Lite SRAM subordinate: single-port word-wide memory behind the bus decoder.
// Handles pipelined single/burst beats, programmable wait states, byte strobes,
// write-to-read forwarding and the two-cycle ERROR response.
module ahb_sram_subordinate #(
  parameter int                 PA_BITS     = 32,
  parameter int                 AHBW        = 64,
  parameter logic [PA_BITS-1:0] BASE        = 'h8000_0000,
  parameter int                 DEPTH       = 1024,
  parameter int                 WAIT_STATES = 0
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL,
  input  logic [PA_BITS-1:0]   HADDR,
  input  logic [1:0]           HTRANS,
  input  logic                 HWRITE,
  input  logic [2:0]           HSIZE,
  input  logic [2:0]           HBURST,
  input  logic [3:0]           HPROT,
  input  logic                 HMASTLOCK,
  input  logic                 HREADY,
  input  logic [AHBW-1:0]      HWDATA,
  input  logic [AHBW/8-1:0]    HWSTRB,
  output logic [AHBW-1:0]      HRDATA,
  output logic                 HREADYOUT,
  output logic                 HRESP
);

  localparam int STRB  = AHBW / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(STRB);
  localparam logic [PA_BITS-1:0] SPAN = PA_BITS'(DEPTH * STRB);
  localparam logic [2:0] MAX_SIZE = 3'(OFF_W);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [IDX_W-1:0]   addr_q;
  logic               wr_q;
  logic [AHBW-1:0]    mem [DEPTH];

  logic [PA_BITS-1:0] offset;
  logic [PA_BITS-1:0] size_mask;
  logic [IDX_W-1:0]   idx;
  logic               err;
  logic               slot_free;
  logic               accept;
  logic               wr_commit;
  logic               rd_now;
  logic [IDX_W-1:0]   rd_idx;
  logic [AHBW-1:0]    rd_word;
  logic               unused_inputs;

  assign offset    = HADDR - BASE;
  assign size_mask = (PA_BITS'(1) << HSIZE) - PA_BITS'(1);
  assign err       = (offset >= SPAN) || ((HADDR & size_mask) != '0) || (HSIZE > MAX_SIZE);
  assign idx       = offset[OFF_W +: IDX_W];

  // A new address phase can only be taken when no data phase is still stalling
  assign slot_free = (state == IDLE) || (state == ERR2) || ((state == DATA) && (cnt == '0));
  assign accept    = slot_free && HSEL && HREADY && HTRANS[1];
  assign wr_commit = (state == DATA) && (cnt == '0) && wr_q;

  // Burst type, protection and lock carry no meaning for a plain SRAM
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  // Zero-wait reads must fetch at the accept edge; otherwise fetch when entering the last cycle
  generate
    if (WAIT_STATES == 0) begin : g_rd_accept
      assign rd_now = accept && !err && !HWRITE;
      assign rd_idx = idx;
    end else begin : g_rd_late
      assign rd_now = (state == DATA) && (cnt == 4'd1) && !wr_q;
      assign rd_idx = addr_q;
    end
  endgenerate

  // Read word with bytes of a same-edge write to the same word merged in
  always_comb begin
    rd_word = mem[rd_idx];
    if (wr_commit && (rd_idx == addr_q)) begin
      for (int i = 0; i < STRB; i++) begin
        if (HWSTRB[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Next-state, wait counting and response outputs
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      IDLE: begin
      end
      DATA: begin
        HREADYOUT = (cnt == '0);
        if (cnt != '0) cnt_nx = cnt - 4'd1;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_nx  = ERR2;
      end
      ERR2: begin
        HRESP = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    if (slot_free) begin
      if (accept && !err) begin
        state_nx = DATA;
        cnt_nx   = WS;
      end else if (accept) begin
        state_nx = ERR1;
        cnt_nx   = '0;
      end else begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    end
  end

  // State and wait counter registers
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the accepted address phase for use in its data phase
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= idx;
      wr_q   <= HWRITE;
    end
  end

  // Commit write data byte-by-byte at the edge that ends the write data phase
  always_ff @(posedge HCLK) begin
    if (HRESETn && wr_commit) begin
      for (int i = 0; i < STRB; i++) begin
        if (HWSTRB[i]) mem[addr_q][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

  // Registered read data, held until the next successful read
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      HRDATA <= '0;
    end else if (rd_now) begin
      HRDATA <= rd_word;
    end
  end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench for ahb_sram_subordinate: three instances (0, 2, 3 wait states),
// a table of directed transfers, randomized traffic against a transaction-level memory
// model, a timed INCR4 burst and a reset in the middle of a stalled write.
module tb_ahb_sram_subordinate;

  localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
  localparam int          LIMIT     = 20000;

  typedef struct {
    bit          isXfer;
    bit          sel;
    logic [1:0]  trans;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [63:0] data;
    logic [7:0]  strb;
    bit          expErr;
    logic [63:0] expRd;
  } xfer_t;

  logic        clk = 1'b0;
  logic        hresetn;
  logic        hsel      [3];
  logic [31:0] haddr     [3];
  logic [1:0]  htrans    [3];
  logic        hwrite    [3];
  logic [2:0]  hsize     [3];
  logic [2:0]  hburst    [3];
  logic [63:0] hwdata    [3];
  logic [7:0]  hwstrb    [3];
  logic [63:0] hrdata    [3];
  logic        hreadyout [3];
  logic        hresp     [3];

  int          checks = 0;
  int          errors = 0;
  xfer_t       xq [$];
  xfer_t       tbl [19];
  logic [63:0] modelMem [3][1024];
  logic [63:0] lastRd [3];

  always #5 clk = ~clk;

  ahb_sram_subordinate #(.PA_BITS(32), .AHBW(64), .BASE(BASE_ADDR), .DEPTH(1024), .WAIT_STATES(0)) u_ws0 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
    .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HREADY(hreadyout[0]), .HWDATA(hwdata[0]), .HWSTRB(hwstrb[0]), .HRDATA(hrdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]));

  ahb_sram_subordinate #(.PA_BITS(32), .AHBW(64), .BASE(BASE_ADDR), .DEPTH(1024), .WAIT_STATES(2)) u_ws2 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
    .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HREADY(hreadyout[1]), .HWDATA(hwdata[1]), .HWSTRB(hwstrb[1]), .HRDATA(hrdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]));

  ahb_sram_subordinate #(.PA_BITS(32), .AHBW(64), .BASE(BASE_ADDR), .DEPTH(1024), .WAIT_STATES(3)) u_ws3 (
    .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel[2]), .HADDR(haddr[2]), .HTRANS(htrans[2]),
    .HWRITE(hwrite[2]), .HSIZE(hsize[2]), .HBURST(hburst[2]), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HREADY(hreadyout[2]), .HWDATA(hwdata[2]), .HWSTRB(hwstrb[2]), .HRDATA(hrdata[2]),
    .HREADYOUT(hreadyout[2]), .HRESP(hresp[2]));

  function automatic int wsOf(input int c);
    return (c == 0) ? 0 : ((c == 1) ? 2 : 3);
  endfunction

  function automatic xfer_t idleItem();
    xfer_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic xfer_t mk(input bit isX, input bit sel, input logic [1:0] trans, input bit write,
                               input logic [31:0] addr, input logic [2:0] size, input logic [63:0] data,
                               input logic [7:0] strb, input bit expErr, input logic [63:0] expRd);
    xfer_t x;
    x = '{default: '0};
    x.isXfer = isX;  x.sel = sel;    x.trans = trans;   x.write = write;
    x.addr = addr;   x.size = size;  x.data = data;     x.strb = strb;
    x.expErr = expErr;  x.expRd = expRd;
    return x;
  endfunction

  // Error rule from the bus contract: outside window, misaligned, or wider than the bus
  function automatic bit isErr(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] off;
    int bytes;
    off   = addr - BASE_ADDR;
    bytes = 1 << size;
    return (off >= 32'd8192) || ((int'(addr[6:0]) % bytes) != 0) || (bytes > 8);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Drive the address phase of 'a' and the write data of the data phase 'd'
  task automatic applyStimulus(input int c, input xfer_t a, input xfer_t d);
    hsel[c]   = a.sel;
    haddr[c]  = a.addr;
    htrans[c] = a.trans;
    hwrite[c] = a.write;
    hsize[c]  = a.size;
    hburst[c] = a.burst;
    hwdata[c] = d.data;
    hwstrb[c] = d.write ? d.strb : 8'h00;
  endtask

  // Pipelined manager: drains xq on channel c, checking every cycle
  task automatic runQueue(input int c, output int dataCycles);
    xfer_t a, d;
    bit haveA, haveD, readyPrev, respBad, ready, resp;
    int waits, guard;
    a = idleItem(); d = a;
    haveA = 0; haveD = 0; readyPrev = 1; respBad = 0;
    waits = 0; guard = 0; dataCycles = 0;
    while ((xq.size() != 0 || haveA || haveD) && guard < LIMIT) begin
      @(posedge clk); #1;
      guard++;
      if (readyPrev) begin
        d = a;
        haveD = haveA && a.isXfer;
        waits = 0;
        respBad = 0;
        if (xq.size() != 0) begin
          a = xq.pop_front();
          haveA = 1;
        end else begin
          a = idleItem();
          haveA = 0;
        end
        applyStimulus(c, a, d);
      end
      ready = hreadyout[c];
      resp  = hresp[c];
      if (haveD) begin
        dataCycles++;
        if (!ready) begin
          waits++;
          if (resp !== d.expErr) respBad = 1;
        end else begin
          checkOutput($sformatf("ch%0d_waits@%h", c, d.addr), 64'(waits), d.expErr ? 64'd1 : 64'(wsOf(c)));
          checkOutput($sformatf("ch%0d_wait_resp@%h", c, d.addr), 64'(respBad), 64'd0);
          checkOutput($sformatf("ch%0d_resp@%h", c, d.addr), 64'(resp), 64'(d.expErr));
          checkOutput($sformatf("ch%0d_rdata@%h", c, d.addr), hrdata[c], d.expRd);
        end
      end else begin
        checkOutput($sformatf("ch%0d_idle_ready", c), 64'(ready), 64'd1);
        checkOutput($sformatf("ch%0d_idle_resp", c), 64'(resp), 64'd0);
      end
      readyPrev = ready;
    end
    checkOutput($sformatf("ch%0d_timeout", c), 64'(guard >= LIMIT), 64'd0);
  endtask

  // Fill 16 consecutive words with known data
  task automatic genPreload(input int c, input int baseWord);
    xfer_t x;
    for (int i = 0; i < 16; i++) begin
      x = mk(1'b1, 1'b1, 2'b10, 1'b1, BASE_ADDR + 32'((baseWord + i) * 8), 3'd3,
             {$urandom, $urandom}, 8'hFF, 1'b0, lastRd[c]);
      modelMem[c][baseWord + i] = x.data;
      xq.push_back(x);
    end
  endtask

  // Random mix of idle/busy/unselected cycles, good transfers and erroring transfers
  task automatic genRandom(input int c, input int n, input int baseWord);
    xfer_t x;
    int kind, w, off;
    for (int i = 0; i < n; i++) begin
      x = idleItem();
      kind = int'($urandom_range(0, 19));
      w = baseWord + int'($urandom_range(0, 15));
      if (kind < 4) begin
        x.sel   = 1'($urandom_range(0, 1));
        x.trans = x.sel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
        x.write = 1'($urandom_range(0, 1));
        x.addr  = BASE_ADDR + 32'(w * 8);
      end else begin
        x.isXfer = 1'b1;
        x.sel    = 1'b1;
        x.trans  = 2'($urandom_range(2, 3));
        x.burst  = 3'($urandom_range(0, 7));
        x.write  = 1'($urandom_range(0, 1));
        x.data   = {$urandom, $urandom};
        x.strb   = 8'($urandom_range(0, 255));
        if (kind == 4) begin
          x.size = 3'd3;
          if ($urandom_range(0, 1) == 0) x.addr = BASE_ADDR + 32'h2000 + 32'(8 * $urandom_range(0, 1023));
          else x.addr = BASE_ADDR - 32'(8 * $urandom_range(1, 64));
        end else if (kind == 5) begin
          x.size = 3'($urandom_range(1, 3));
          off = 2 * int'($urandom_range(0, 3)) + 1;
          x.addr = BASE_ADDR + 32'(w * 8 + off);
        end else if (kind == 6) begin
          x.size = 3'($urandom_range(4, 7));
          x.addr = BASE_ADDR + 32'(w * 8);
        end else begin
          x.size = 3'($urandom_range(0, 3));
          off = (int'($urandom_range(0, 7)) >> x.size) << x.size;
          x.addr = BASE_ADDR + 32'(w * 8 + off);
        end
        x.expErr = isErr(x.addr, x.size);
        if (!x.expErr && x.write) begin
          for (int b = 0; b < 8; b++)
            if (x.strb[b]) modelMem[c][w][8*b +: 8] = x.data[8*b +: 8];
        end else if (!x.expErr) begin
          lastRd[c] = modelMem[c][w];
        end
        x.expRd = lastRd[c];
      end
      xq.push_back(x);
    end
  endtask

  initial begin
    int dc;
    xfer_t x;

    // Directed vectors on the zero-wait instance
    tbl[0]  = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0010, 3'd3, 64'h1122334455667788, 8'hFF, 1'b0, 64'h0);
    tbl[1]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0010, 3'd3, 64'h0, 8'h00, 1'b0, 64'h1122334455667788);
    tbl[2]  = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0010, 3'd3, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0, 64'h1122334455667788);
    tbl[3]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0010, 3'd3, 64'h0, 8'h00, 1'b0, 64'h11223344BBBBBBBB);
    tbl[4]  = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0000, 3'd3, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 64'h11223344BBBBBBBB);
    tbl[5]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_2000, 3'd3, 64'h0, 8'h00, 1'b1, 64'h11223344BBBBBBBB);
    tbl[6]  = mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h8000_0000, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0);
    tbl[7]  = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0004, 3'd3, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b1, 64'h11223344BBBBBBBB);
    tbl[8]  = mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0000, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0);
    tbl[9]  = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0123456789ABCDEF);
    tbl[10] = mk(1'b1, 1'b1, 2'b11, 1'b0, 32'h8000_0004, 3'd2, 64'h0, 8'h00, 1'b0, 64'h0123456789ABCDEF);
    tbl[11] = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0020, 3'd4, 64'h5555555555555555, 8'hFF, 1'b1, 64'h0123456789ABCDEF);
    tbl[12] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h7FFF_FFF8, 3'd3, 64'h0, 8'h00, 1'b1, 64'h0123456789ABCDEF);
    tbl[13] = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_1FF8, 3'd3, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 64'h0123456789ABCDEF);
    tbl[14] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_1FF8, 3'd3, 64'h0, 8'h00, 1'b0, 64'hDEADBEEFCAFEF00D);
    tbl[15] = mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_1FFC, 3'd2, 64'h1234567800000000, 8'hF0, 1'b0, 64'hDEADBEEFCAFEF00D);
    tbl[16] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_1FF8, 3'd3, 64'h0, 8'h00, 1'b0, 64'h12345678CAFEF00D);
    tbl[17] = mk(1'b0, 1'b0, 2'b10, 1'b1, 32'h8000_0000, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0);
    tbl[18] = mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0000, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0123456789ABCDEF);

    hresetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      applyStimulus(c, idleItem(), idleItem());
      lastRd[c] = 64'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("ch%0d_reset_ready", c), 64'(hreadyout[c]), 64'd1);
      checkOutput($sformatf("ch%0d_reset_resp", c), 64'(hresp[c]), 64'd0);
      checkOutput($sformatf("ch%0d_reset_rdata", c), hrdata[c], 64'h0);
    end
    hresetn = 1'b1;

    $display("[TB] directed table, zero wait states");
    for (int i = 0; i < 19; i++) begin
      xq.push_back(tbl[i]);
      if (tbl[i].isXfer) lastRd[0] = tbl[i].expRd;
    end
    runQueue(0, dc);

    $display("[TB] random traffic, zero wait states");
    genPreload(0, 32);
    genRandom(0, 200, 32);
    runQueue(0, dc);

    $display("[TB] INCR4 burst, two wait states");
    genPreload(1, 32);
    runQueue(1, dc);
    for (int i = 0; i < 4; i++) begin
      x = mk(1'b1, 1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b0, 32'h8000_0100 + 32'(8 * i), 3'd3,
             64'h0, 8'h00, 1'b0, modelMem[1][32 + i]);
      x.burst = 3'b011;
      lastRd[1] = x.expRd;
      xq.push_back(x);
    end
    runQueue(1, dc);
    checkOutput("ch1_burst_cycles", 64'(dc), 64'd12);

    $display("[TB] random traffic, two wait states");
    genRandom(1, 150, 32);
    runQueue(1, dc);

    $display("[TB] reset during a stalled write, three wait states");
    xq.push_back(mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0040, 3'd3, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b0, 64'h0));
    xq.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0040, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0F0E0D0C0B0A0908));
    runQueue(2, dc);
    @(posedge clk); #1;
    applyStimulus(2, mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0040, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0), idleItem());
    @(posedge clk); #1;
    applyStimulus(2, idleItem(), mk(1'b1, 1'b1, 2'b10, 1'b1, 32'h8000_0040, 3'd3,
                                    64'hFFFF0000FFFF0000, 8'hFF, 1'b0, 64'h0));
    checkOutput("ch2_wait1_ready", 64'(hreadyout[2]), 64'd0);
    @(posedge clk); #1;
    checkOutput("ch2_wait2_ready", 64'(hreadyout[2]), 64'd0);
    hresetn = 1'b0;
    @(posedge clk); #1;
    hresetn = 1'b1;
    applyStimulus(2, idleItem(), idleItem());
    checkOutput("ch2_postreset_ready", 64'(hreadyout[2]), 64'd1);
    checkOutput("ch2_postreset_resp", 64'(hresp[2]), 64'd0);
    checkOutput("ch2_postreset_rdata", hrdata[2], 64'h0);
    xq.push_back(mk(1'b1, 1'b1, 2'b10, 1'b0, 32'h8000_0040, 3'd3, 64'h0, 8'h00, 1'b0, 64'h0F0E0D0C0B0A0908));
    runQueue(2, dc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
